// File: rtl/clk_freq_encoder.sv
// Measures clk_in against clk over a fixed window and encodes the edge count
// into one of four frequency codes (or flags error when none is close enough).
`timescale 1ns/1ps
//   state  | meaning
//   IDLE   | waiting for a registered start request
//   COUNT  | counting clk_in rising edges for WINDOW clk cycles
//   DECIDE | match edge count against the code table, publish result
module clk_freq_encoder #(
  parameter int FIRST_FREQ  = 1,
  parameter int SECOND_FREQ = 2,
  parameter int THIRD_FREQ  = 4,
  parameter int FOURTH_FREQ = 8,
  parameter int WINDOW      = 256,
  parameter int UNIT_EDGES  = 4,
  parameter int TOL         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_in,
  input  logic       start,
  output logic       busy,
  output logic       valid,
  output logic       error,
  output logic [1:0] clk_freq_enc,
  output logic [3:0] clock_frequency_enc,
  output logic [7:0] edge_count
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);

  localparam int TGT0 = FIRST_FREQ  * UNIT_EDGES;
  localparam int TGT1 = SECOND_FREQ * UNIT_EDGES;
  localparam int TGT2 = THIRD_FREQ  * UNIT_EDGES;
  localparam int TGT3 = FOURTH_FREQ * UNIT_EDGES;

  typedef enum logic [1:0] {IDLE, COUNT, DECIDE} state_t;

  state_t           state_q;
  logic             sync_meta_q, sync_q, sync_prev_q, edge_q;
  logic             start_q;
  logic [WIN_W-1:0] win_q;
  logic [7:0]       cnt_q;
  logic             busy_q, valid_q, error_q;
  logic [1:0]       enc_q;
  logic [3:0]       freq_q;
  logic [7:0]       edge_count_q;

  logic             match_d;
  logic [1:0]       code_d;
  logic [3:0]       freq_d;

  function automatic logic near(input int n, input int tgt);
    int d;
    d = n - tgt;
    if (d < 0) d = -d;
    return (d <= TOL);
  endfunction

  // Priority order 00..11: the lowest matching code wins.
  always_comb begin
    match_d = 1'b1;
    code_d  = 2'b00;
    freq_d  = 4'(FIRST_FREQ);
    if (near(int'(cnt_q), TGT0)) begin
      code_d = 2'b00;
      freq_d = 4'(FIRST_FREQ);
    end else if (near(int'(cnt_q), TGT1)) begin
      code_d = 2'b01;
      freq_d = 4'(SECOND_FREQ);
    end else if (near(int'(cnt_q), TGT2)) begin
      code_d = 2'b10;
      freq_d = 4'(THIRD_FREQ);
    end else if (near(int'(cnt_q), TGT3)) begin
      code_d = 2'b11;
      freq_d = 4'(FOURTH_FREQ);
    end else begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_meta_q  <= 1'b0;
      sync_q       <= 1'b0;
      sync_prev_q  <= 1'b0;
      edge_q       <= 1'b0;
      start_q      <= 1'b0;
      win_q        <= '0;
      cnt_q        <= 8'd0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      enc_q        <= 2'b00;
      freq_q       <= 4'd0;
      edge_count_q <= 8'd0;
    end else begin
      sync_meta_q <= clk_in;
      sync_q      <= sync_meta_q;
      sync_prev_q <= sync_q;
      edge_q      <= sync_q & ~sync_prev_q;
      // Requests are only captured in IDLE, so a start seen while busy is dropped.
      start_q     <= start && (state_q == IDLE);
      valid_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_q) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
            win_q   <= WIN_LOAD;
            cnt_q   <= 8'd0;
          end
        end
        COUNT: begin
          if (edge_q && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
          if (win_q == '0) state_q <= DECIDE;
          else             win_q   <= win_q - WIN_W'(1);
        end
        DECIDE: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          valid_q      <= 1'b1;
          edge_count_q <= cnt_q;
          error_q      <= ~match_d;
          if (match_d) begin
            enc_q  <= code_d;
            freq_q <= freq_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy                = busy_q;
  assign valid               = valid_q;
  assign error               = error_q;
  assign clk_freq_enc        = enc_q;
  assign clock_frequency_enc = freq_q;
  assign edge_count          = edge_count_q;

endmodule

// File: doc/clk_freq_encoder.md
CLK_FREQ_ENCODER -- requirements
Module: clk_freq_encoder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- FIRST_FREQ, 1, frequency unit value for code 2'b00.
- SECOND_FREQ, 2, frequency unit value for code 2'b01.
- THIRD_FREQ, 4, frequency unit value for code 2'b10.
- FOURTH_FREQ, 8, frequency unit value for code 2'b11.
- WINDOW, 256, measurement window length in clk cycles.
- UNIT_EDGES, 4, clk_in rising edges per window for a frequency value of 1.
- TOL, 1, allowed +/- edge-count error for a code match.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, reference clock; one clock for all logic.
- rst, in, 1, asynchronous reset, active-high.
- clk_in, in, 1, clock under measurement; asynchronous to clk.
- start, in, 1, single-cycle measurement request.
- busy, out, 1, measurement in progress.
- valid, out, 1, one-cycle result strobe.
- error, out, 1, last measurement matched no code.
- clk_freq_enc, out, 2, encoded frequency code.
- clock_frequency_enc, out, 4, frequency value of the matched code.
- edge_count, out, 8, raw edge count of the last window.

Function
REQ-003 clk_in SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector. Both SHALL run continuously, including in IDLE.
REQ-004 The FSM SHALL have the states IDLE, COUNT and DECIDE.
REQ-005 IDLE behaviour:
- start=1 SHALL transition to COUNT.
- Entering COUNT SHALL clear the window counter and the edge counter.
REQ-006 COUNT SHALL last exactly WINDOW clk cycles, then transition to DECIDE.
REQ-007 In COUNT, each cycle with an edge-detect pulse SHALL increment the 8-bit edge counter.
REQ-008 The edge counter SHALL saturate at 255 and never wrap.
REQ-009 DECIDE SHALL last one cycle, then return to IDLE.
REQ-010 In DECIDE, code k SHALL match when |N - FREQ_k*UNIT_EDGES| <= TOL, where N is the edge count.
REQ-011 Codes SHALL be checked in the order 00, 01, 10, 11, and the first match SHALL win.
REQ-012 On a match, in the cycle after DECIDE:
- clk_freq_enc SHALL be set to k.
- clock_frequency_enc SHALL be set to FREQ_k, truncated to 4 bits.
- error SHALL be 0.
REQ-013 On no match, clk_freq_enc and clock_frequency_enc SHALL hold their previous values and error SHALL be 1.
REQ-014 edge_count SHALL be loaded with N in every DECIDE, whether or not a code matched.
REQ-015 valid SHALL be high for exactly one cycle, the cycle after DECIDE.
REQ-016 Latency SHALL be fixed: valid rises WINDOW+2 clk cycles after the clk edge that samples start=1.
REQ-017 busy SHALL be 1 in COUNT and DECIDE and 0 otherwise.
REQ-018 start SHALL be ignored while busy=1; a measurement in progress SHALL NOT be restarted or extended.
REQ-019 start SHALL be accepted in the same cycle that valid is high, because the FSM is already in IDLE.
REQ-020 error SHALL stay set until the next DECIDE that produces a match.
REQ-021 A clk_in edge whose detect pulse lands outside COUNT SHALL NOT be counted.
REQ-022 Correct results require clk_in frequency <= clk/4; faster clk_in SHALL yield an undercount, reported via error.
REQ-023 A static clk_in SHALL give N=0, which SHALL produce error=1.

Reset
REQ-024 While rst=1, asynchronously:
- FSM SHALL be in IDLE.
- busy, valid and error SHALL be 0.
- clk_freq_enc SHALL be 2'b00.
- clock_frequency_enc SHALL be 4'd0.
- edge_count SHALL be 0.
- synchronizer, edge detector and counters SHALL be 0.
REQ-025 Reset asserted mid-COUNT SHALL abort the measurement with no valid pulse. After release, the block SHALL wait in IDLE for a new start.

Verification (clk period 10 ns, default parameters)
REQ-026 clk_in period 640 ns, one start -> valid at start+258 cycles, clk_freq_enc=00, clock_frequency_enc=1, edge_count=4+/-1, error=0.
REQ-027 clk_in periods 320, 160 and 80 ns, one start each -> codes 01, 10, 11; clock_frequency_enc 2, 4, 8; edge_count about 8, 16, 32.
REQ-028 clk_in held at 0, start -> error=1, edge_count=0, clk_freq_enc keeps its prior value; a later 160 ns run -> code 10 and error=0.
REQ-029 clk_in period 240 ns (about 10-11 edges) -> error=1; clk_in period 20 ns -> error=1, with no counter wrap.
REQ-030 start pulses at cycles 10 and 100 of a running window -> exactly one valid at start+258; busy stays high throughout.
REQ-031 rst asserted at COUNT cycle 100 -> all outputs 0 immediately and no valid; after a new start, a normal result is produced.
